// File: rtl/master_port.sv
// Master-side request stage: buffers local commands, drives the req/ack handshake and returns read data.
// Optional ack watchdog enabled by defining MASTER_TIMEOUT_EN.
module master_port #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk_pll,
  input  logic                  rst_in,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  master_req,
  output logic                  master_cmd,
  output logic [ADDR_WIDTH-1:0] master_addr,
  output logic [DATA_WIDTH-1:0] master_wdata,
  input  logic                  master_ack,
  input  logic                  master_resp,
  input  logic [DATA_WIDTH-1:0] master_rdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            outstanding,
  output logic                  busy,
  output logic                  err_unexp,
  output logic                  err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PW    = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  cmd_t            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e          state_q, state_d;
  logic            master_req_q, master_req_d;
  cmd_t            issue_q, issue_d;
  logic [2:0]      outstanding_q, outstanding_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic            err_unexp_q, err_unexp_d;

  logic            empty, full, push, pop;
  logic            rd_ack, resp_ok, head_credit, timeout_hit;
  logic [3:0]      credit_base;
  cmd_t            head;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  assign rd_ack  = master_req_q && master_ack && !issue_q.we;
  assign resp_ok = master_resp && (outstanding_q != 3'd0);

  // Credit counts the read being acked this cycle so back-to-back issue never overshoots.
  assign credit_base = {1'b0, outstanding_q} + {3'b000, rd_ack};
  assign head_credit = head.we || (credit_base < 4'(MAX_OUTSTANDING));

`ifdef MASTER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_timeout_q, err_timeout_d;

  assign timeout_hit = (state_q == REQ) && !master_ack && (wd_q == WD_LAST);

  always_comb begin
    wd_d          = ((state_q == REQ) && !master_ack && !timeout_hit) ? wd_q + 8'd1 : 8'd0;
    err_timeout_d = err_timeout_q || timeout_hit;
  end

  always_ff @(posedge clk_pll or negedge rst_in) begin
    if (!rst_in) begin
      wd_q          <= 8'd0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    master_req_d = master_req_q;
    issue_d      = issue_q;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && head_credit) begin
          pop          = 1'b1;
          issue_d      = head;
          master_req_d = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (master_ack) begin
          if (!empty && head_credit) begin
            pop     = 1'b1;
            issue_d = head;
          end else begin
            master_req_d = 1'b0;
            state_d      = IDLE;
          end
        end else if (timeout_hit) begin
          master_req_d = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    unique case ({rd_ack, resp_ok})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase

    rd_valid_d  = resp_ok;
    rd_data_d   = resp_ok ? master_rdata : rd_data_q;
    err_unexp_d = err_unexp_q || (master_resp && (outstanding_q == 3'd0));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_pll or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      master_req_q  <= 1'b0;
      issue_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= 3'd0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      master_req_q  <= master_req_d;
      issue_q       <= issue_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      err_unexp_q   <= err_unexp_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_pll) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  end

  assign cmd_ready    = !full;
  assign master_req   = master_req_q;
  assign master_cmd   = issue_q.we;
  assign master_addr  = issue_q.addr;
  assign master_wdata = issue_q.wdata;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign outstanding  = outstanding_q;
  assign err_unexp    = err_unexp_q;
  assign busy         = !empty || master_req_q || (outstanding_q != 3'd0);

endmodule
